// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus for the sequential divider.
interface seq_divider_if;
   localparam int unsigned DW = 8;
   localparam int unsigned VW = 4;

   logic          start;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          busy;
   logic          done;
   logic          div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider: 8-bit dividend / 4-bit divisor,
// one quotient bit per clock behind a start/done handshake.
module seq_divider (
   input logic         clk,
   input logic         rst,
   seq_divider_if.slave bus
);
   localparam int unsigned DW = 8;
   localparam int unsigned VW = 4;
   localparam int unsigned RW = VW + 1;
   localparam int unsigned CW = 3;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [DW-1:0] dq;
   logic [RW-1:0] rem;
   logic [VW-1:0] dvs;
   logic [CW-1:0] cnt;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          busy;
   logic          done;
   logic          div_by_zero;

   logic [RW-1:0] t;
   logic          ge;
   logic [RW-1:0] rem_nxt;
   logic [DW-1:0] dq_nxt;
   logic          unused_rem_msb;

   // One restoring step: bring in the next dividend bit, subtract if it fits.
   always_comb begin
      t       = {rem[VW-1:0], dq[DW-1]};
      ge      = (t >= {1'b0, dvs});
      rem_nxt = ge ? (t - {1'b0, dvs}) : t;
      dq_nxt  = {dq[DW-2:0], ge};
   end

   // The partial remainder stays below the divisor after each step, so its top bit never feeds back.
   assign unused_rem_msb = rem[RW-1];

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         dq          <= '0;
         rem         <= '0;
         dvs         <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.divisor != '0) begin
                     dq          <= bus.dividend;
                     rem         <= '0;
                     dvs         <= bus.divisor;
                     cnt         <= '0;
                     div_by_zero <= 1'b0;
                     busy        <= 1'b1;
                     state       <= RUN;
                  end else begin
                     quotient    <= {DW{1'b1}};
                     remainder   <= '0;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     state       <= DONE;
                  end
               end
            end
            RUN: begin
               dq  <= dq_nxt;
               rem <= rem_nxt;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(DW - 1)) begin
                  quotient  <= dq_nxt;
                  remainder <= rem_nxt[VW-1:0];
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.quotient    = quotient;
   assign bus.remainder   = remainder;
   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.div_by_zero = div_by_zero;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, directed corner
// sequences and an exhaustive sweep, all results checked via a scoreboard.
module tb_seq_divider;
   logic clk = 1'b0;
   logic rst = 1'b1;

   seq_divider_if bus ();

   seq_divider dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [3:0] b;
      logic [7:0] q;
      logic [3:0] r;
      logic       dz;
   } vec_t;

   typedef struct packed {
      logic [7:0] q;
      logic [3:0] r;
      logic       dz;
   } res_t;

   res_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         compared++;
         if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_done: got q=%0d r=%0d dz=%0b with nothing expected",
                     bus.quotient, bus.remainder, bus.div_by_zero);
         end else begin
            res_t e;
            e = sb.pop_front();
            if (bus.quotient !== e.q || bus.remainder !== e.r ||
                bus.div_by_zero !== e.dz || bus.busy !== 1'b0) begin
               mismatched++;
               $display("FAIL result: got q=%0d r=%0d dz=%0b busy=%0b, want q=%0d r=%0d dz=%0b busy=0",
                        bus.quotient, bus.remainder, bus.div_by_zero, bus.busy, e.q, e.r, e.dz);
            end
         end
      end
   end

   task automatic check(input string name, input int got, input int want);
      compared++;
      if (got != want) begin
         mismatched++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   // Counts negedges before done shows up, and how many of them had busy high.
   task automatic wait_done(output int n, output int nb, output bit ok);
      n = 0; nb = 0; ok = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (bus.done) begin
            ok = 1'b1;
            break;
         end
         if (bus.busy) nb++;
         n++;
      end
      if (!ok) check("done_timeout", 0, 1);
   endtask

   task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] eq, input logic [3:0] er, input logic edz);
      int n, nb;
      bit ok;
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
      @(posedge clk);
      sb.push_back('{q: eq, r: er, dz: edz});
      #1;
      bus.start = 1'b0;
      bus.dividend = 8'($urandom); bus.divisor = 4'($urandom);
      wait_done(n, nb, ok);
      if (!ok) begin
         void'(sb.pop_front());
         return;
      end
      check("latency", n, edz ? 0 : 8);
      check("busy_cycles", nb, edz ? 0 : 8);
      @(negedge clk);
      check("idle_after_done", int'({bus.done, bus.busy}), 0);
   endtask

   initial begin
      vec_t vecs[8];
      int   n, nb;
      bit   ok;

      vecs[0] = '{a: 8'd200, b: 4'd7,  q: 8'd28,  r: 4'd4, dz: 1'b0};
      vecs[1] = '{a: 8'd143, b: 4'd13, q: 8'd11,  r: 4'd0, dz: 1'b0};
      vecs[2] = '{a: 8'd225, b: 4'd15, q: 8'd15,  r: 4'd0, dz: 1'b0};
      vecs[3] = '{a: 8'd255, b: 4'd1,  q: 8'd255, r: 4'd0, dz: 1'b0};
      vecs[4] = '{a: 8'd0,   b: 4'd5,  q: 8'd0,   r: 4'd0, dz: 1'b0};
      vecs[5] = '{a: 8'd7,   b: 4'd9,  q: 8'd0,   r: 4'd7, dz: 1'b0};
      vecs[6] = '{a: 8'd50,  b: 4'd0,  q: 8'hFF,  r: 4'd0, dz: 1'b1};
      vecs[7] = '{a: 8'd250, b: 4'd3,  q: 8'd83,  r: 4'd1, dz: 1'b0};

      bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", int'({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero}), 0);
      rst = 1'b0;

      foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);

      // A start pulse mid-run with new operands must be ignored.
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 8'd250; bus.divisor = 4'd3;
      @(posedge clk);
      sb.push_back('{q: 8'd83, r: 4'd1, dz: 1'b0});
      #1 bus.start = 1'b0;
      repeat (2) @(negedge clk);
      bus.start = 1'b1; bus.dividend = 8'd10; bus.divisor = 4'd2;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(n, nb, ok);
      if (!ok) sb.delete();
      @(negedge clk);
      check("midrun_start_ignored", int'(bus.busy), 0);
      run_op(8'd10, 4'd2, 8'd5, 4'd0, 1'b0);

      // Reset in the middle of a run clears everything.
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrun_reset_outputs", int'({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero}), 0);
      run_op(8'd100, 4'd10, 8'd10, 4'd0, 1'b0);

      // Start held high re-triggers every 10 cycles.
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
      sb.push_back('{q: 8'd28, r: 4'd4, dz: 1'b0});
      sb.push_back('{q: 8'd28, r: 4'd4, dz: 1'b0});
      wait_done(n, nb, ok);
      if (ok) begin
         wait_done(n, nb, ok);
         if (ok) check("held_start_period", n + 1, 10);
      end
      bus.start = 1'b0;
      if (!ok) sb.delete();
      repeat (2) @(negedge clk);

      // Exhaustive sweep and product inversion.
      for (int a = 0; a < 256; a++)
         for (int b = 1; b < 16; b++)
            run_op(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0);
      for (int a = 1; a < 16; a++)
         for (int b = 1; b < 16; b++)
            run_op(8'(a * b), 4'(b), 8'(a), 4'd0, 1'b0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
